// File: rtl/tcp_hdr_tx_serializer.sv
// TCP header TX serializer: optional pseudo-header checksum (macro TCP_TX_CSUM_EN), then NB = 160/OUT_W beats MSB-first.
// Latency: first beat 17 cycles after accept with TCP_TX_CSUM_EN, 1 cycle without.
// Backpressure: one header in flight; input rdy low outside IDLE, beats held stable while ser_rdy is low.
module tcp_hdr_tx_serializer #(
  parameter int         OUT_W    = 32,
  parameter logic [7:0] IP_PROTO = 8'd6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_tcp_hdr_val,
  input  logic [31:0]      tx_src_ip,
  input  logic [31:0]      tx_dst_ip,
  input  logic [159:0]     tx_tcp_hdr,
  output logic             tx_tcp_hdr_rdy,
  output logic             ser_val,
  output logic [OUT_W-1:0] ser_data,
  output logic             ser_last,
  output logic [31:0]      ser_src_ip,
  output logic [31:0]      ser_dst_ip,
  input  logic             ser_rdy
);

  localparam int NB = 160 / OUT_W;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

`ifdef TCP_TX_CSUM_EN
  typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t         state_q, state_d;
  logic [159:0]   hdr_q, hdr_d;
  logic [31:0]    src_q, src_d;
  logic [31:0]    dst_q, dst_d;
  logic [BW-1:0]  beat_q, beat_d;

`ifdef TCP_TX_CSUM_EN
  logic [15:0]    acc_q, acc_d;
  logic [3:0]     widx_q, widx_d;
  logic [255:0]   csum_words;
  logic [15:0]    csum_word;
  logic [16:0]    sum17;
  logic [15:0]    sum16;

  // Pseudo-header followed by the TCP header with its checksum field zeroed.
  assign csum_words = {src_q, dst_q, 8'h00, IP_PROTO, 16'd20, hdr_q[159:32], 16'h0000, hdr_q[15:0]};
  assign csum_word  = csum_words[{4'd15 - widx_q, 4'b0000} +: 16];
  assign sum17      = {1'b0, acc_q} + {1'b0, csum_word};
  assign sum16      = sum17[15:0] + {15'd0, sum17[16]};
`endif

  always_comb begin
    state_d        = state_q;
    hdr_d          = hdr_q;
    src_d          = src_q;
    dst_d          = dst_q;
    beat_d         = beat_q;
    tx_tcp_hdr_rdy = 1'b0;
`ifdef TCP_TX_CSUM_EN
    acc_d          = acc_q;
    widx_d         = widx_q;
`endif
    case (state_q)
      IDLE: begin
        tx_tcp_hdr_rdy = !rst;
        if (tx_tcp_hdr_val && !rst) begin
          hdr_d  = tx_tcp_hdr;
          src_d  = tx_src_ip;
          dst_d  = tx_dst_ip;
          beat_d = '0;
`ifdef TCP_TX_CSUM_EN
          acc_d   = '0;
          widx_d  = '0;
          state_d = CSUM;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef TCP_TX_CSUM_EN
      CSUM: begin
        acc_d  = sum16;
        widx_d = widx_q + 4'd1;
        if (widx_q == 4'd15) begin
          hdr_d[31:16] = ~sum16;
          state_d      = SEND;
        end
      end
`endif
      SEND: begin
        // The header register shifts so the current beat is always its top OUT_W bits.
        if (ser_rdy) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
            hdr_d  = hdr_q << OUT_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      beat_q  <= '0;
`ifdef TCP_TX_CSUM_EN
      acc_q   <= '0;
      widx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      beat_q  <= beat_d;
`ifdef TCP_TX_CSUM_EN
      acc_q   <= acc_d;
      widx_q  <= widx_d;
`endif
    end
  end

  assign ser_val    = (state_q == SEND);
  assign ser_data   = ser_val ? hdr_q[159 -: OUT_W] : '0;
  assign ser_last   = ser_val && (beat_q == LAST_BEAT);
  assign ser_src_ip = src_q;
  assign ser_dst_ip = dst_q;

endmodule

// File: tb/tb_tcp_hdr_tx_serializer.sv
// Bench for tcp_hdr_tx_serializer: 32-bit and 16-bit instances, directed and random headers vs a checksum model.
module tb_tcp_hdr_tx_serializer;

`ifdef TCP_TX_CSUM_EN
  localparam int LAT     = 17;
  localparam bit CSUM_ON = 1'b1;
`else
  localparam int LAT     = 1;
  localparam bit CSUM_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  src_i = '0, dst_i = '0;
  logic [159:0] hdr_i = '0;
  logic         cur_val = 1'b0;
  logic         srdy = 1'b1;
  logic         sel16 = 1'b0;

  logic         rdy32, v32, l32, rdy16, v16, l16;
  logic [31:0]  d32, sip32, dip32, sip16, dip16;
  logic [15:0]  d16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tcp_hdr_tx_serializer #(.OUT_W(32), .IP_PROTO(8'd6)) dut32 (
    .clk(clk), .rst(rst),
    .tx_tcp_hdr_val(cur_val && !sel16), .tx_src_ip(src_i), .tx_dst_ip(dst_i),
    .tx_tcp_hdr(hdr_i), .tx_tcp_hdr_rdy(rdy32),
    .ser_val(v32), .ser_data(d32), .ser_last(l32),
    .ser_src_ip(sip32), .ser_dst_ip(dip32), .ser_rdy(srdy)
  );

  tcp_hdr_tx_serializer #(.OUT_W(16), .IP_PROTO(8'd6)) dut16 (
    .clk(clk), .rst(rst),
    .tx_tcp_hdr_val(cur_val && sel16), .tx_src_ip(src_i), .tx_dst_ip(dst_i),
    .tx_tcp_hdr(hdr_i), .tx_tcp_hdr_rdy(rdy16),
    .ser_val(v16), .ser_data(d16), .ser_last(l16),
    .ser_src_ip(sip16), .ser_dst_ip(dip16), .ser_rdy(srdy)
  );

  wire        o_val  = sel16 ? v16 : v32;
  wire        o_last = sel16 ? l16 : l32;
  wire        o_rdy  = sel16 ? rdy16 : rdy32;
  wire [31:0] o_data = sel16 ? {16'h0000, d16} : d32;
  wire [31:0] o_sip  = sel16 ? sip16 : sip32;
  wire [31:0] o_dip  = sel16 ? dip16 : dip32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference checksum: plain sum of all 16-bit words, folded at the end.
  function automatic logic [15:0] model_csum(input logic [31:0] s, input logic [31:0] d,
                                             input logic [159:0] h);
    int unsigned  sum;
    logic [159:0] z;
    z = h;
    z[31:16] = 16'h0000;
    sum = s[31:16] + s[15:0] + d[31:16] + d[15:0] + 6 + 20;
    for (int i = 0; i < 10; i++) sum += z[159 - 16 * i -: 16];
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    return ~16'(sum);
  endfunction

  function automatic logic [159:0] exp_hdr(input logic [31:0] s, input logic [31:0] d,
                                           input logic [159:0] h);
    logic [159:0] e;
    logic [15:0]  c;
    e = h;
    c = model_csum(s, d, h);
    e[31:16] = CSUM_ON ? c : h[31:16];
    return e;
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode: 0 always ready, 1 toggling 1010..., 2 random. abort_at >= 0 resets while that beat is shown.
  task automatic run_hdr(input logic [31:0] s, input logic [31:0] d, input logic [159:0] h,
                         input int mode, input bit keep, input int abort_at);
    logic [159:0] e, t;
    logic [31:0]  eb;
    int w, nb, cyc, k, guard;
    bit got, tog;
    w  = sel16 ? 16 : 32;
    nb = 160 / w;
    e  = exp_hdr(s, d, h);
    src_i = s; dst_i = d; hdr_i = h; cur_val = 1'b1;
    @(negedge clk);
    chk("idle_rdy", {63'd0, o_rdy}, 64'd1);
    chk("idle_val", {63'd0, o_val}, 64'd0);
    @(posedge clk); #1;
    if (!keep) cur_val = 1'b0;
    src_i = $urandom; dst_i = $urandom; hdr_i = rand160();
    cyc = 0; got = 0;
    while (cyc < 60 && !got) begin
      @(negedge clk); cyc++;
      if (o_val) got = 1;
      else chk("busy_rdy", {63'd0, o_rdy}, 64'd0);
    end
    chk("first_beat_cycle", 64'(cyc), 64'(LAT));
    k = 0; guard = 0; tog = 1'b1;
    while (k < nb && guard < 200) begin
      if (guard > 0) @(negedge clk);
      guard++;
      t  = e << (k * w);
      eb = (w == 32) ? t[159:128] : {16'h0000, t[159:144]};
      chk("beat_val", {63'd0, o_val}, 64'd1);
      chk($sformatf("beat%0d_data", k), {32'd0, o_data}, {32'd0, eb});
      chk("beat_last", {63'd0, o_last}, {63'd0, (k == nb - 1)});
      chk("ips", {o_sip, o_dip}, {s, d});
      chk("send_rdy", {63'd0, o_rdy}, 64'd0);
      if (k == abort_at) begin
        rst = 1'b1; #1;
        chk("rst_val", {63'd0, o_val}, 64'd0);
        chk("rst_data", {32'd0, o_data}, 64'd0);
        chk("rst_last_rdy", {62'd0, o_last, o_rdy}, 64'd0);
        chk("rst_ips", {o_sip, o_dip}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; srdy = 1'b1; cur_val = 1'b0;
        return;
      end
      case (mode)
        0:       srdy = 1'b1;
        1:       begin srdy = tog; tog = ~tog; end
        default: srdy = 1'($urandom_range(0, 1));
      endcase
      if (srdy) k++;
    end
    chk("all_beats_sent", 64'(k), 64'(nb));
    @(posedge clk); #1;
    srdy = 1'b1;
  endtask

  logic [159:0] hdr1, hdr5, hdr0;

  initial begin
    hdr1 = {16'h1F90, 16'hC000, 32'h0, 32'h0, 32'h5012FFFF, 16'h0000, 16'h0000};
    hdr5 = hdr1;
    hdr5[31:16] = 16'hABCD;
    // All-zero IPs plus one word of 0xFFE5 make the one's-complement sum 0xFFFF.
    hdr0 = {16'h0, 16'h0, 32'hFFE50000, 32'h0, 32'h0, 16'h0000, 16'h0000};

    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_rdy", {62'd0, rdy32, rdy16}, 64'd0);
    chk("reset_val", {62'd0, v32, v16}, 64'd0);
    chk("reset_last", {62'd0, l32, l16}, 64'd0);
    chk("reset_data", {16'd0, d16, d32}, 64'd0);
    chk("reset_ips32", {sip32, dip32}, 64'd0);
    chk("reset_ips16", {sip16, dip16}, 64'd0);
    rst = 1'b0;

    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 0, 1'b0, -1);
    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 1, 1'b0, -1);
    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 0, 1'b1, -1);
    run_hdr(32'hC0A80101, 32'h08080808, hdr5, 0, 1'b0, -1);
    run_hdr(32'h0, 32'h0, hdr0, 2, 1'b0, -1);
    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 0, 1'b0, 2);
    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 0, 1'b0, -1);

    sel16 = 1'b1;
    run_hdr(32'h0A000001, 32'h0A000002, hdr1, 0, 1'b0, -1);
    run_hdr($urandom, $urandom, rand160(), 2, 1'b1, -1);
    run_hdr($urandom, $urandom, rand160(), 1, 1'b0, -1);

    sel16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_hdr($urandom, $urandom, rand160(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
